// File: rtl/mvu_loop_agu.sv
// mvu_loop_agu: nested-loop address generator/sequencer for one MVU memory stream
// Ports: clk, rst (sync, active-high); start kicks a command built from baseaddr,
// jump (NJUMPS signed jumps), length (NJUMPS-1 loop lengths) and countdown (beats);
// addr/z/valid form the beat, accepted on valid&&ready; busy flags a command, done pulses at the end.
// Optional: MVU_LOOP_AGU_PERF_EN adds stall_cnt, a saturating count of RUN cycles stalled by !ready.
module mvu_loop_agu #(
  parameter int BADDR   = 15,
  parameter int BJUMP   = 15,
  parameter int BLENGTH = 15,
  parameter int NJUMPS  = 5,
  parameter int BCNTDWN = 29
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [BADDR-1:0]              baseaddr,
  input  logic [NJUMPS*BJUMP-1:0]       jump,
  input  logic [(NJUMPS-1)*BLENGTH-1:0] length,
  input  logic [BCNTDWN-1:0]            countdown,
  output logic [BADDR-1:0]              addr,
  output logic [$clog2(NJUMPS)-1:0]     z,
  output logic                          valid,
  input  logic                          ready,
  output logic                          busy,
  output logic                          done
`ifdef MVU_LOOP_AGU_PERF_EN
  ,
  output logic [31:0]                   stall_cnt
`endif
);
  localparam int ZW = $clog2(NJUMPS);
  localparam int NL = NJUMPS - 1;
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t                      state_q, state_d;
  logic [BADDR-1:0]            addr_q, addr_d;
  logic [ZW-1:0]               z_q, z_d;
  logic [BCNTDWN-1:0]          rem_q, rem_d;
  logic [NJUMPS*BJUMP-1:0]     jump_q, jump_d;
  logic [NL*BLENGTH-1:0]       len_q, len_d;
  logic [BLENGTH-1:0]          cnt_q [NL];
  logic [BLENGTH-1:0]          cnt_d [NL];
  logic [ZW-1:0]               jidx;
  logic signed [BJUMP-1:0]     jsel;
  logic [BADDR-1:0]            jext;
  logic                        accept, beat;
  assign accept = state_q == IDLE && start;
  assign beat   = state_q == RUN && ready;
  assign addr   = addr_q;
  assign z      = z_q;
  assign valid  = state_q == RUN;
  assign busy   = state_q == RUN;
  assign done   = state_q == FIN;
  // Lowest loop level whose counter is still nonzero selects the jump;
  // if every level is exhausted the outermost jump is taken.
  always_comb begin
    jidx = ZW'(NJUMPS - 1);
    for (int l = NL - 1; l >= 0; l--) if (cnt_q[l] != '0) jidx = ZW'(l);
  end
  assign jsel = jump_q[int'(jidx)*BJUMP +: BJUMP];
  assign jext = BADDR'(jsel);
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    z_d     = z_q;
    rem_d   = rem_q;
    jump_d  = jump_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    if (accept) begin
      state_d = countdown != '0 ? RUN : FIN;
      if (countdown != '0) begin
        jump_d = jump;
        len_d  = length;
        addr_d = baseaddr;
        z_d    = ZW'(NJUMPS - 1);
        rem_d  = countdown;
        for (int l = 0; l < NL; l++) cnt_d[l] = length[l*BLENGTH +: BLENGTH];
      end
    end else if (beat) begin
      rem_d = rem_q - BCNTDWN'(1);
      if (rem_q == BCNTDWN'(1)) state_d = FIN;
      else begin
        addr_d = addr_q + jext;
        z_d    = jidx;
        for (int l = 0; l < NL; l++)
          cnt_d[l] = l < int'(jidx) ? len_q[l*BLENGTH +: BLENGTH] :
                     l == int'(jidx) ? cnt_q[l] - BLENGTH'(1) : cnt_q[l];
      end
    end else if (state_q == FIN) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      z_q     <= '0;
      rem_q   <= '0;
      jump_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      z_q     <= z_d;
      rem_q   <= rem_d;
      jump_q  <= jump_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end
`ifdef MVU_LOOP_AGU_PERF_EN
  logic [31:0] stall_q, stall_d;
  assign stall_cnt = stall_q;
  always_comb stall_d = accept ? '0 : (state_q == RUN && !ready && stall_q != '1) ? stall_q + 32'd1 : stall_q;
  always_ff @(posedge clk) begin
    if (rst) stall_q <= '0;
    else stall_q <= stall_d;
  end
`endif
endmodule
